// File: rtl/f_fetch_if.sv
// Fetch-stage bundle: hazard/decode control in, instruction-memory address and F/D register contents out.
// D_ExcCode exists only when FETCH_ADEL_EN is defined.
interface f_fetch_if;
    logic        F_Stall;
    logic        D_Redirect;
    logic [31:0] D_NPC_NPC;
    logic [31:0] F_IM_RData;
    logic [31:0] F_IM_Addr;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        D_Valid;
`ifdef FETCH_ADEL_EN
    logic [4:0]  D_ExcCode;
`endif

    // master = pipeline control + instruction memory, slave = the fetch stage
    modport master (
        output F_Stall, D_Redirect, D_NPC_NPC, F_IM_RData,
        input  F_IM_Addr, F_PC, D_PC, D_Instr, D_Valid
`ifdef FETCH_ADEL_EN
        , input D_ExcCode
`endif
    );

    modport slave (
        input  F_Stall, D_Redirect, D_NPC_NPC, F_IM_RData,
        output F_IM_Addr, F_PC, D_PC, D_Instr, D_Valid
`ifdef FETCH_ADEL_EN
        , output D_ExcCode
`endif
    );
endinterface

// File: rtl/f_fetch_stage.sv
// P5 fetch stage: PC register plus the F/D pipeline register, delay-slot style redirect (no flush).
// Optional FETCH_ADEL_EN adds the instruction-address error check and the D_ExcCode output.
module f_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef FETCH_ADEL_EN
    , parameter logic [31:0] IM_BASE  = 32'h0000_3000
    , parameter int unsigned IM_WORDS = 4096
`endif
) (
    input  logic      clk,
    input  logic      reset_n,
    f_fetch_if.slave  fif
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc_q, dpc_d;
    logic [31:0] instr_q, instr_d;
    logic        vld_q, vld_d;

`ifdef FETCH_ADEL_EN
    // Upper bound kept 33 bits wide so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    logic [4:0] exc_q, exc_d;
    logic       adel;

    assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_END);
`endif

    always_comb begin
        pc_d    = pc_q;
        dpc_d   = dpc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
`ifdef FETCH_ADEL_EN
        exc_d   = exc_q;
`endif
        // Stall outranks redirect; the held D instruction re-asserts redirect later.
        if (!fif.F_Stall) begin
            pc_d    = fif.D_Redirect ? fif.D_NPC_NPC : pc_q + 32'd4;
            dpc_d   = pc_q;
            instr_d = fif.F_IM_RData;
            vld_d   = 1'b1;
`ifdef FETCH_ADEL_EN
            exc_d   = 5'd0;
            if (adel) begin
                instr_d = 32'h0;
                exc_d   = 5'd4;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            dpc_q   <= 32'h0;
            instr_q <= 32'h0;
            vld_q   <= 1'b0;
`ifdef FETCH_ADEL_EN
            exc_q   <= 5'd0;
`endif
        end else begin
            pc_q    <= pc_d;
            dpc_q   <= dpc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
`ifdef FETCH_ADEL_EN
            exc_q   <= exc_d;
`endif
        end
    end

    assign fif.F_IM_Addr = pc_q;
    assign fif.F_PC      = pc_q;
    assign fif.D_PC      = dpc_q;
    assign fif.D_Instr   = instr_q;
    assign fif.D_Valid   = vld_q;
`ifdef FETCH_ADEL_EN
    assign fif.D_ExcCode = exc_q;
`endif
endmodule

// File: tb/tb_f_fetch_stage.sv
// Scoreboard bench for f_fetch_stage: directed pipeline scenarios plus randomized stall/redirect traffic.
// Expected F/D state is computed from a behavioural PC model and checked one edge later by a monitor.
module tb_f_fetch_stage;
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int unsigned WORDS = 4096;
    localparam logic [31:0] DC    = 32'h1234_5678;

    typedef struct {
        logic [31:0] f_pc;
        logic [31:0] d_pc;
        logic [31:0] d_instr;
        logic        d_valid;
        logic [4:0]  d_exc;
    } exp_t;

    logic clk;
    logic reset_n;
    f_fetch_if fif();

    f_fetch_stage dut (.clk(clk), .reset_n(reset_n), .fif(fif));

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // model state
    logic [31:0] m_pc, m_dpc, m_instr;
    logic        m_vld;
    logic [4:0]  m_exc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h3401_0001;
        return {a[15:0], ~a[15:0]} ^ 32'h0BAD_F00D;
    endfunction

    assign fif.F_IM_RData = rom(fif.F_IM_Addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [4:0] dut_exc();
`ifdef FETCH_ADEL_EN
        return fif.D_ExcCode;
`else
        return 5'd0;
`endif
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
`ifdef FETCH_ADEL_EN
        return (a % 4 != 0) || (a < BASE) || (64'(a) >= 64'(BASE) + 64'(WORDS) * 4);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc = BASE; m_dpc = 0; m_instr = 0; m_vld = 0; m_exc = 0;
    endtask

    // Called just after a falling edge; drives inputs, predicts the state after the next rising edge.
    task automatic step(input bit stall, input bit redir, input logic [31:0] npc);
        exp_t e;
        fif.F_Stall    = stall;
        fif.D_Redirect = redir;
        fif.D_NPC_NPC  = redir ? npc : DC;
        if (!stall) begin
            m_dpc   = m_pc;
            m_vld   = 1'b1;
            m_instr = bad_addr(m_pc) ? 32'h0 : rom(m_pc);
            m_exc   = bad_addr(m_pc) ? 5'd4 : 5'd0;
            m_pc    = redir ? npc : m_pc + 32'd4;
        end
        e.f_pc = m_pc; e.d_pc = m_dpc; e.d_instr = m_instr; e.d_valid = m_vld; e.d_exc = m_exc;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_now(input string tag);
        chk({tag, ".F_PC"},    fif.F_PC, m_pc);
        chk({tag, ".D_PC"},    fif.D_PC, m_dpc);
        chk({tag, ".D_Instr"}, fif.D_Instr, m_instr);
        chk({tag, ".D_Valid"}, 32'(fif.D_Valid), 32'(m_vld));
        chk({tag, ".D_Exc"},   32'(dut_exc()), 32'(m_exc));
    endtask

    // monitor: the stage updates every edge, so one expectation is consumed per edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("F_PC",      fif.F_PC, e.f_pc);
            chk("F_IM_Addr", fif.F_IM_Addr, e.f_pc);
            chk("D_PC",      fif.D_PC, e.d_pc);
            chk("D_Instr",   fif.D_Instr, e.d_instr);
            chk("D_Valid",   32'(fif.D_Valid), 32'(e.d_valid));
            chk("D_Exc",     32'(dut_exc()), 32'(e.d_exc));
        end
    end

    initial begin
        reset_n        = 1'b0;
        fif.F_Stall    = 1'b0;
        fif.D_Redirect = 1'b0;
        fif.D_NPC_NPC  = DC;
        model_reset();
        #12;
        check_now("reset");
        chk("reset.F_IM_Addr", fif.F_IM_Addr, BASE);
        @(negedge clk);
        reset_n = 1'b1;

        // first fetch, then straight-line run
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        // redirect with F_PC=0x3010: slot instruction still enters D
        step(0, 1, 32'h3040);
        step(0, 0, 0);
        // stall two edges while redirect is held, then unstall with redirect
        step(1, 1, 32'h3100);
        step(1, 1, 32'h3100);
        step(0, 1, 32'h3100);
        step(0, 0, 0);
        // PC wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 32'h3020);
        step(0, 0, 0);
        // async reset mid-cycle while stalled
        step(0, 1, 32'h3020);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("pre_areset.F_PC", fif.F_PC, 32'h3020);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_now("areset");
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);

`ifdef FETCH_ADEL_EN
        step(0, 1, 32'h3002);
        step(0, 1, 32'h2FFC);
        step(0, 1, 32'h3004);
        step(0, 0, 0);
        step(0, 1, BASE + WORDS * 4 - 4);
        step(0, 0, 0);
        step(0, 0, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit st, rd;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            tgt = BASE + 32'($urandom_range(0, WORDS - 1)) * 4;
`ifdef FETCH_ADEL_EN
            if ($urandom_range(0, 5) == 0) tgt = tgt ^ 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) tgt = $urandom();
`endif
            step(st, rd, tgt);
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
